pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage CPU, directly upstream of the branch-target adder.
- Holds the PC, issues requests to the synchronous instruction BRAM and presents the IF/ID pipeline values.
- Produces ins_inc_addr, the PC+1 of the instruction in decode, which the branch-target adder consumes.
- Redirects the PC when the resolved branch target ins_br_addr comes back from execute.

Parameters:
- ADDR_W, 10: PC / instruction-memory address width.
- INSTR_W, 32: instruction width.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- run  in  1  software run enable; 0 stops fetching.
- stall  in  1  hazard stall from decode; freezes the fetch stage.
- br_taken  in  1  branch resolved taken this cycle.
- ins_br_addr  in  ADDR_W  branch target from the branch-target adder.
- imem_addr  out  ADDR_W  BRAM read address (combinational).
- imem_en  out  1  BRAM read enable; when 0 the BRAM holds its output.
- imem_rdata  in  INSTR_W  BRAM data, valid one cycle after an enabled request.
- if_id_valid  out  1  instruction on if_id_instr is valid.
- if_id_instr  out  INSTR_W  fetched instruction; equals imem_rdata.
- if_id_pc  out  ADDR_W  address of if_id_instr.
- ins_inc_addr  out  ADDR_W  if_id_pc+1, feeds the branch-target adder.

Behaviour:
- Reset (rst_n=0 at a clk edge): pc<=RESET_PC, if_id_valid<=0, if_id_pc<=0, ins_inc_addr<=0, state<=IDLE. While rst_n=0, imem_en=0.
- States:
  - IDLE: imem_en=0; if_id_valid<=0 each cycle. IDLE->RUN on a cycle with run=1 (first request is issued in the next cycle).
  - RUN: RUN->IDLE on a cycle with run=0. No request is issued in that cycle. The IDLE state rule clears if_id_valid at the next edge.
- Address mux: imem_addr = br_taken ? ins_br_addr : pc. This is combinational, so a redirect costs no extra fetch bubble.
- Enable: imem_en = (state==RUN && run) && (br_taken || !stall).
- Accepted request (imem_en=1):
  - pc<=imem_addr+1.
  - if_id_pc<=imem_addr.
  - ins_inc_addr<=imem_addr+1.
  - if_id_valid<=1.
- Latency: the address issued at edge t produces instr/pc/valid after edge t+1. The sustained rate is 1 instruction per cycle.
- Stall (stall=1, br_taken=0): pc, if_id_pc, ins_inc_addr and if_id_valid hold. imem_en=0 keeps if_id_instr stable.
- Branch over stall: br_taken=1 overrides stall. The target is requested the same cycle and is presented after the next edge with valid=1. Squashing the wrong-path instruction already in decode is downstream's job.
- br_taken while IDLE, or while run=0: pc<=ins_br_addr, no request is issued, and the next RUN resumes at the target.
- Wrap-around: all +1 arithmetic is modulo 2^ADDR_W, with no carry out. A PC of 2^ADDR_W-1 is followed by 0; ins_inc_addr for that PC is 0.
- rst_n=0 mid-stall or mid-branch: reset wins, and all in-flight state is discarded.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt[31:0] and stall_cnt[31:0], both cleared on reset.
  - fetch_cnt increments on every accepted request.
  - stall_cnt increments on every RUN cycle with run=1, stall=1 and br_taken=0.
  - Both counters saturate at 0xFFFFFFFF.
- Undefined: neither port nor counter logic exists; the rest of the behaviour is identical.

Test Plan:
- Reset then run=1, no stall/branch -> imem_addr 0,1,2,3 on consecutive cycles. if_id_pc=0,1,2 with valid=1 from the second cycle after run. ins_inc_addr=if_id_pc+1.
- Stall held 3 cycles at pc=5 -> imem_en=0, and if_id_pc=4 / ins_inc_addr=5 / valid=1 frozen. Release -> imem_addr continues at 5.
- br_taken=1, ins_br_addr=0x1F0, with stall=1 in the same cycle -> imem_addr=0x1F0 that cycle. Next cycle if_id_pc=0x1F0, ins_inc_addr=0x1F1, valid=1, imem_addr=0x1F1.
- Jump to 0x3FF -> if_id_pc=0x3FF with ins_inc_addr=0x000, and the next imem_addr is 0x000.
- run dropped at pc=8, br_taken to 0x20 while IDLE, run raised -> valid=0 during IDLE, and the first fetch is at 0x20.
- rst_n=0 for one cycle mid-stream -> next cycle valid=0 and pc=RESET_PC. With FETCH_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction
// BRAM and presents the IF/ID values plus PC+1 for the branch-target adder.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module pc_fetch_unit #(
  parameter int unsigned       ADDR_W   = 10,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  ins_br_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [ADDR_W-1:0]  ins_inc_addr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   if_pc_q, if_pc_d;
  logic [ADDR_W-1:0]   inc_q, inc_d;
  logic                valid_q, valid_d;
  logic                active_c;

  // BRAM data is already aligned with the registered IF/ID values
  assign if_id_instr  = imem_rdata;
  assign if_id_valid  = valid_q;
  assign if_id_pc     = if_pc_q;
  assign ins_inc_addr = inc_q;

  // Next-state, address mux and request enable
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    if_pc_d   = if_pc_q;
    inc_d     = inc_q;
    valid_d   = valid_q;
    active_c  = (state_q == ST_RUN) && run;
    imem_addr = br_taken ? ins_br_addr : pc_q;
    imem_en   = rst_n && active_c && (br_taken || !stall);

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (run) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!run) state_d = ST_IDLE;
      end
    endcase

    if (imem_en) begin
      pc_d    = imem_addr + ADDR_W'(1);
      if_pc_d = imem_addr;
      inc_d   = imem_addr + ADDR_W'(1);
      valid_d = 1'b1;
    end else if (br_taken && !active_c) begin
      // Redirect while not fetching: resume at the target on the next RUN
      pc_d = ins_br_addr;
    end
  end

  // State and pipeline registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      if_pc_q <= '0;
      inc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if_pc_q <= if_pc_d;
      inc_q   <= inc_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_d, stall_cnt_d;
  logic        stall_cyc_c;

  // Saturating performance counters
  always_comb begin
    fetch_cnt_d = fetch_cnt;
    stall_cnt_d = stall_cnt;
    stall_cyc_c = active_c && stall && !br_taken;
    if (imem_en && (fetch_cnt != 32'hFFFF_FFFF)) fetch_cnt_d = fetch_cnt + 32'd1;
    if (stall_cyc_c && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      fetch_cnt <= fetch_cnt_d;
      stall_cnt <= stall_cnt_d;
    end
  end
`else
  // Counters not built
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a driver issues per-cycle vectors and
// queues their expected outputs; a monitor pops and compares each cycle.
module tb_pc_fetch_unit;

  localparam int unsigned AW = 10;
  localparam int unsigned IW = 32;

  typedef struct {
    logic          rst_n;
    logic          run;
    logic          stall;
    logic          br;
    logic [AW-1:0] br_addr;
    logic          en;
    logic [AW-1:0] addr;
    logic          valid;
    logic [AW-1:0] pc;
    logic [AW-1:0] inc;
`ifdef FETCH_PERF_CNT_EN
    logic          chk_cnt;
    logic [31:0]   fc;
    logic [31:0]   sc;
`endif
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic          stall;
  logic          br_taken;
  logic [AW-1:0] ins_br_addr;
  logic [AW-1:0] imem_addr;
  logic          imem_en;
  logic [IW-1:0] imem_rdata;
  logic          if_id_valid;
  logic [IW-1:0] if_id_instr;
  logic [AW-1:0] if_id_pc;
  logic [AW-1:0] ins_inc_addr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   fetch_cnt;
  logic [31:0]   stall_cnt;
`endif

  vec_t stim_q[$];
  vec_t exp_q[$];
  int   n_vec  = 0;
  int   n_cmp  = 0;
  int   n_miss = 0;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .run(run), .stall(stall), .br_taken(br_taken),
    .ins_br_addr(ins_br_addr), .imem_addr(imem_addr), .imem_en(imem_en),
    .imem_rdata(imem_rdata), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .ins_inc_addr(ins_inc_addr)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] a);
    return {12'hC0D, 10'h0, a};
  endfunction

  // Synchronous BRAM model: holds output when not enabled
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= instr_of(imem_addr);
  end

  task automatic add(input logic r, input logic rn, input logic st, input logic br,
                     input logic [AW-1:0] ba, input logic en, input logic [AW-1:0] a,
                     input logic v, input logic [AW-1:0] p, input logic [AW-1:0] inc);
    vec_t t;
    t.rst_n = r; t.run = rn; t.stall = st; t.br = br; t.br_addr = ba;
    t.en = en; t.addr = a; t.valid = v; t.pc = p; t.inc = inc;
`ifdef FETCH_PERF_CNT_EN
    t.chk_cnt = 1'b0; t.fc = 0; t.sc = 0;
`endif
    stim_q.push_back(t);
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic cnt(input logic [31:0] fc, input logic [31:0] sc);
    vec_t t;
    t = stim_q.pop_back();
    t.chk_cnt = 1'b1; t.fc = fc; t.sc = sc;
    stim_q.push_back(t);
  endtask
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL vec%0d %s: got %h expected %h", n_vec, name, act, exp);
    end
  endtask

  // Monitor: compares every cycle's outputs against the queued expectation
  always @(negedge clk) begin
    #3;
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      chk("imem_en", 32'(imem_en), 32'(e.en));
      chk("imem_addr", 32'(imem_addr), 32'(e.addr));
      chk("if_id_valid", 32'(if_id_valid), 32'(e.valid));
      chk("if_id_pc", 32'(if_id_pc), 32'(e.pc));
      chk("ins_inc_addr", 32'(ins_inc_addr), 32'(e.inc));
      if (e.valid) chk("if_id_instr", if_id_instr, instr_of(e.pc));
`ifdef FETCH_PERF_CNT_EN
      if (e.chk_cnt) begin
        chk("fetch_cnt", fetch_cnt, e.fc);
        chk("stall_cnt", stall_cnt, e.sc);
      end
`endif
      n_vec++;
    end
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; stall = 1'b0; br_taken = 1'b0; ins_br_addr = '0;
    imem_rdata = '0;
    //  rst run stl br  br_addr  en addr     v  pc       inc
    add(0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h000, 10'h000);
    add(0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h000, 10'h000);
    // straight-line fetch from reset
    add(1, 1, 0, 0, 10'h000, 0, 10'h000, 0, 10'h000, 10'h000);
    add(1, 1, 0, 0, 10'h000, 1, 10'h000, 0, 10'h000, 10'h000);
    add(1, 1, 0, 0, 10'h000, 1, 10'h001, 1, 10'h000, 10'h001);
    add(1, 1, 0, 0, 10'h000, 1, 10'h002, 1, 10'h001, 10'h002);
    add(1, 1, 0, 0, 10'h000, 1, 10'h003, 1, 10'h002, 10'h003);
    add(1, 1, 0, 0, 10'h000, 1, 10'h004, 1, 10'h003, 10'h004);
    // three-cycle stall at pc=5, then release
    add(1, 1, 1, 0, 10'h000, 0, 10'h005, 1, 10'h004, 10'h005);
    add(1, 1, 1, 0, 10'h000, 0, 10'h005, 1, 10'h004, 10'h005);
    add(1, 1, 1, 0, 10'h000, 0, 10'h005, 1, 10'h004, 10'h005);
    add(1, 1, 0, 0, 10'h000, 1, 10'h005, 1, 10'h004, 10'h005);
    // branch overriding stall
    add(1, 1, 1, 1, 10'h1F0, 1, 10'h1F0, 1, 10'h005, 10'h006);
    add(1, 1, 0, 0, 10'h000, 1, 10'h1F1, 1, 10'h1F0, 10'h1F1);
    // jump to top of address space, wrap
    add(1, 1, 0, 1, 10'h3FF, 1, 10'h3FF, 1, 10'h1F1, 10'h1F2);
    add(1, 1, 0, 0, 10'h000, 1, 10'h000, 1, 10'h3FF, 10'h000);
    add(1, 1, 0, 0, 10'h000, 1, 10'h001, 1, 10'h000, 10'h001);
    add(1, 1, 0, 1, 10'h007, 1, 10'h007, 1, 10'h001, 10'h002);
    // drop run at pc=8, redirect while idle, resume at target
    add(1, 0, 0, 0, 10'h000, 0, 10'h008, 1, 10'h007, 10'h008);
    add(1, 0, 0, 1, 10'h020, 0, 10'h020, 1, 10'h007, 10'h008);
    add(1, 0, 0, 0, 10'h000, 0, 10'h020, 0, 10'h007, 10'h008);
    add(1, 1, 0, 0, 10'h000, 0, 10'h020, 0, 10'h007, 10'h008);
    add(1, 1, 0, 0, 10'h000, 1, 10'h020, 0, 10'h007, 10'h008);
    add(1, 1, 0, 0, 10'h000, 1, 10'h021, 1, 10'h020, 10'h021);
    // reset in the middle of a stall
    add(1, 1, 1, 0, 10'h000, 0, 10'h022, 1, 10'h021, 10'h022);
    add(0, 1, 1, 0, 10'h000, 0, 10'h022, 1, 10'h021, 10'h022);
`ifdef FETCH_PERF_CNT_EN
    cnt(32'd14, 32'd4);
`endif
    add(1, 1, 0, 0, 10'h000, 0, 10'h000, 0, 10'h000, 10'h000);
`ifdef FETCH_PERF_CNT_EN
    cnt(32'd0, 32'd0);
`endif
    add(1, 1, 1, 1, 10'h010, 1, 10'h010, 0, 10'h000, 10'h000);
    add(1, 1, 0, 0, 10'h000, 1, 10'h011, 1, 10'h010, 10'h011);
    // reset in the middle of a branch
    add(0, 1, 0, 1, 10'h055, 0, 10'h055, 1, 10'h011, 10'h012);
`ifdef FETCH_PERF_CNT_EN
    cnt(32'd2, 32'd0);
`endif
    add(1, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h000, 10'h000);
`ifdef FETCH_PERF_CNT_EN
    cnt(32'd0, 32'd0);
`endif

    while (stim_q.size() > 0) begin
      vec_t s;
      s = stim_q.pop_front();
      @(negedge clk);
      rst_n = s.rst_n; run = s.run; stall = s.stall;
      br_taken = s.br; ins_br_addr = s.br_addr;
      exp_q.push_back(s);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
